// File: rtl/spi_reg_pkg.sv
// Shared address map, field widths and default sizing for the SPI register bank.
// The address decoder lives here so the bank and any checker agree on one map.
package spi_reg_pkg;

    localparam int ADDR_W         = 7;
    localparam int DATA_W         = 8;
    localparam int FWD_W          = ADDR_W + DATA_W;
    localparam int STATUS_W       = 32;
    localparam int DEF_NUM_RW     = 16;
    localparam int DEF_FIFO_DEPTH = 4;

    localparam logic [6:0] ADDR_CMD    = 7'h10;
    localparam logic [6:0] ADDR_FLAGS  = 7'h11;
    localparam logic [6:0] ADDR_WRCNT  = 7'h12;
    localparam logic [6:0] ADDR_STATUS = 7'h20;
    localparam logic [6:0] ADDR_FWD    = 7'h40;

    typedef enum logic [2:0] {
        REG_RW     = 3'd0,
        REG_CMD    = 3'd1,
        REG_FLAGS  = 3'd2,
        REG_WRCNT  = 3'd3,
        REG_STATUS = 3'd4,
        REG_FWD    = 3'd5,
        REG_RSVD   = 3'd6
    } reg_kind_e;

    // Classify an address; num_rw never exceeds 16 so RW space cannot reach 0x10.
    function automatic reg_kind_e decode_addr(input logic [6:0] addr, input int num_rw);
        reg_kind_e kind;
        if (int'(addr) < num_rw) begin
            kind = REG_RW;
        end else if (addr == ADDR_CMD) begin
            kind = REG_CMD;
        end else if (addr == ADDR_FLAGS) begin
            kind = REG_FLAGS;
        end else if (addr == ADDR_WRCNT) begin
            kind = REG_WRCNT;
        end else if (addr[6:2] == ADDR_STATUS[6:2]) begin
            kind = REG_STATUS;
        end else if (addr[6] == ADDR_FWD[6]) begin
            kind = REG_FWD;
        end else begin
            kind = REG_RSVD;
        end
        return kind;
    endfunction

endpackage

// File: rtl/spi_fwd_fifo.sv
// Synchronous FIFO carrying {address, data} forwarded writes to the tuner config logic.
// A push into a full queue is accepted only when a pop frees the slot on the same edge.
module spi_fwd_fifo
    import spi_reg_pkg::*;
#(
    parameter  int DEPTH = DEF_FIFO_DEPTH,
    parameter  int WIDTH = FWD_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full,
    output logic [LVL_W-1:0] o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_level == {LVL_W{1'b0}});
    assign o_full    = (r_level == LVL_W'(DEPTH));
    assign o_level   = r_level;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage write; when full with a pop, the slot being vacated is reused.
    always_ff @(posedge CLK) begin
        if (w_do_push && !RST) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_level  <= {LVL_W{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/spi_reg_bank.sv
// Register bank behind an SPI slave: RW control bytes, command strobes, flags,
// write counter, status readback and a forwarded-write queue.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int NUM_RW     = DEF_NUM_RW,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     SPI_ENA,
    input  logic [ADDR_W-1:0]        SPI_ADDRESS,
    input  logic [DATA_W-1:0]        SPI_DATA,
    output logic [DATA_W-1:0]        DATA_OUT,
    output logic [NUM_RW*DATA_W-1:0] CTRL_REGS,
    output logic [DATA_W-1:0]        CMD_STROBE,
    input  logic [STATUS_W-1:0]      STATUS_IN,
    output logic                     FWD_VALID,
    output logic [ADDR_W-1:0]        FWD_ADDR,
    output logic [DATA_W-1:0]        FWD_DATA,
    input  logic                     FWD_READY
);

    localparam int IDX_W = (NUM_RW > 1) ? $clog2(NUM_RW) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] r_ctrl [NUM_RW];
    logic [DATA_W-1:0] r_cmd_strobe;
    logic [DATA_W-1:0] r_wrcnt;
    logic [DATA_W-1:0] r_data_out;
    logic              r_ovf;

    reg_kind_e         w_kind;
    logic [IDX_W-1:0]  w_idx;
    logic              w_push;
    logic              w_pop;
    logic              w_ovf_evt;
    logic [FWD_W-1:0]  w_head;
    logic              w_empty;
    logic              w_full;
    logic [LVL_W-1:0]  w_level;
    logic [7:0]        w_level_ext;
    logic [2:0]        w_lvl_sat;
    logic [DATA_W-1:0] w_flags;
    logic [DATA_W-1:0] w_rd_data;

    assign w_kind      = decode_addr(SPI_ADDRESS, NUM_RW);
    assign w_idx       = SPI_ADDRESS[IDX_W-1:0];
    assign w_push      = SPI_ENA & (w_kind == REG_FWD);
    assign w_pop       = FWD_READY & ~w_empty;
    assign w_ovf_evt   = w_push & w_full & ~w_pop;
    assign w_level_ext = {{(8-LVL_W){1'b0}}, w_level};
    assign w_flags     = {1'b0, w_lvl_sat, 1'b0, w_full, w_empty, r_ovf};

    spi_fwd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FWD_W)
    ) u_fwd_fifo (
        .CLK         (CLK),
        .RST         (RST),
        .i_push      (w_push),
        .i_push_data ({SPI_ADDRESS, SPI_DATA}),
        .i_pop       (FWD_READY),
        .o_head      (w_head),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_level     (w_level)
    );

    // Level field is only three bits wide, so deeper queues saturate at 7.
    always_comb begin
        w_lvl_sat = 3'd0;
        if (w_level_ext > 8'd7) begin
            w_lvl_sat = 3'd7;
        end else begin
            w_lvl_sat = w_level_ext[2:0];
        end
    end

    // Readback mux for whatever address the slave is presenting right now.
    always_comb begin
        w_rd_data = 8'h00;
        case (w_kind)
            REG_RW:     w_rd_data = r_ctrl[w_idx];
            REG_FLAGS:  w_rd_data = w_flags;
            REG_WRCNT:  w_rd_data = r_wrcnt;
            REG_STATUS: w_rd_data = STATUS_IN[{SPI_ADDRESS[1:0], 3'b000} +: 8];
            default:    w_rd_data = 8'h00;
        endcase
    end

    // RW control bytes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int n = 0; n < NUM_RW; n++) begin
                r_ctrl[n] <= 8'h00;
            end
        end else if (SPI_ENA && (w_kind == REG_RW)) begin
            r_ctrl[w_idx] <= SPI_DATA;
        end
    end

    // Command pulse, sticky overflow (a new overflow beats a W1C clear) and write counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cmd_strobe <= 8'h00;
            r_ovf        <= 1'b0;
            r_wrcnt      <= 8'h00;
        end else begin
            r_cmd_strobe <= (SPI_ENA && (w_kind == REG_CMD)) ? SPI_DATA : 8'h00;
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (SPI_ENA && (w_kind == REG_FLAGS) && SPI_DATA[0]) begin
                r_ovf <= 1'b0;
            end
            if (SPI_ENA) begin
                r_wrcnt <= (w_kind == REG_WRCNT) ? 8'h00 : (r_wrcnt + 8'h01);
            end
        end
    end

    // Registered readback, one cycle behind SPI_ADDRESS.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_data_out <= 8'h00;
        end else begin
            r_data_out <= w_rd_data;
        end
    end

    for (genvar n = 0; n < NUM_RW; n++) begin : g_ctrl_out
        assign CTRL_REGS[n*DATA_W +: DATA_W] = r_ctrl[n];
    end

    assign DATA_OUT   = r_data_out;
    assign CMD_STROBE = r_cmd_strobe;
    assign FWD_VALID  = ~w_empty;
    assign FWD_ADDR   = w_head[FWD_W-1:DATA_W];
    assign FWD_DATA   = w_head[DATA_W-1:0];

endmodule
